// File: rtl/valu_elem_seq_if.sv
// valu_elem_seq_if: instruction, ALU-operand and writeback signals of the element sequencer.
interface valu_elem_seq_if #(
    parameter int VLMAX = 8,
    parameter int IW    = $clog2(VLMAX) + 1
);
    logic                start;
    logic                start_ready;
    logic [4:0]          op;
    logic [IW-1:0]       vl;
    logic                vm_en;
    logic                use_scalar;
    logic [31:0]         scalar;
    logic [32*VLMAX-1:0] vs1_data;
    logic [32*VLMAX-1:0] vs2_data;
    logic [VLMAX-1:0]    v0_mask;
    logic [31:0]         alu_opd1;
    logic [31:0]         alu_opd2;
    logic [4:0]          alu_op;
    logic                alu_vm;
    logic [31:0]         alu_result;
    logic                wb_valid;
    logic                wb_ready;
    logic [IW-1:0]       wb_idx;
    logic [31:0]         wb_data;
    logic                busy;
    logic                done;
    modport master (
        output start, op, vl, vm_en, use_scalar, scalar, vs1_data, vs2_data, v0_mask,
               alu_result, wb_ready,
        input  start_ready, alu_opd1, alu_opd2, alu_op, alu_vm, wb_valid, wb_idx, wb_data,
               busy, done
    );
    modport slave (
        input  start, op, vl, vm_en, use_scalar, scalar, vs1_data, vs2_data, v0_mask,
               alu_result, wb_ready,
        output start_ready, alu_opd1, alu_opd2, alu_op, alu_vm, wb_valid, wb_idx, wb_data,
               busy, done
    );
endinterface

// File: rtl/valu_elem_seq.sv
// valu_elem_seq: steps one vector instruction through the ALU an element per cycle, with a registered writeback stream.
module valu_elem_seq #(
    parameter int VLMAX = 8
) (
    input logic           clk,
    input logic           rst,
    valu_elem_seq_if.slave bus
);
    localparam int IW = $clog2(VLMAX) + 1;
    localparam int EW = $clog2(VLMAX);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, vl_q, vl_d, wb_idx_q, wb_idx_d, vl_clamp;
    logic [4:0]          op_q, op_d;
    logic                vm_en_q, vm_en_d, use_scalar_q, use_scalar_d, wb_valid_q, wb_valid_d;
    logic [31:0]         scalar_q, scalar_d, wb_data_q, wb_data_d;
    logic [32*VLMAX-1:0] vs1_q, vs1_d, vs2_q, vs2_d;
    logic [VLMAX-1:0]    mask_q, mask_d;
    logic [EW-1:0]       eidx;
    logic                accept, run, issue, last, retire;
    assign bus.start_ready = (state_q == IDLE) && !rst;
    assign accept   = bus.start && bus.start_ready;
    assign vl_clamp = (bus.vl > IW'(VLMAX)) ? IW'(VLMAX) : bus.vl;
    assign run      = state_q == RUN;
    assign issue    = run && (!wb_valid_q || bus.wb_ready);
    assign retire   = wb_valid_q && bus.wb_ready;
    assign last     = idx_q == vl_q - IW'(1);
    // idx reaches vl_q only after the final issue, when the ALU ports are gated off anyway
    assign eidx     = idx_q[EW-1:0];
    assign bus.alu_opd1 = run ? vs2_q[32*eidx +: 32] : '0;
    assign bus.alu_opd2 = !run ? '0 : use_scalar_q ? scalar_q : vs1_q[32*eidx +: 32];
    assign bus.alu_op   = run ? op_q : '0;
    assign bus.alu_vm   = run && (!vm_en_q || mask_q[eidx]);
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_idx   = wb_idx_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
    always_comb begin
        op_d         = accept ? bus.op : op_q;
        vl_d         = accept ? vl_clamp : vl_q;
        vm_en_d      = accept ? bus.vm_en : vm_en_q;
        use_scalar_d = accept ? bus.use_scalar : use_scalar_q;
        scalar_d     = accept ? bus.scalar : scalar_q;
        vs1_d        = accept ? bus.vs1_data : vs1_q;
        vs2_d        = accept ? bus.vs2_data : vs2_q;
        mask_d       = accept ? bus.v0_mask : mask_q;
        idx_d        = accept ? '0 : issue ? idx_q + IW'(1) : idx_q;
        wb_data_d    = issue ? bus.alu_result : wb_data_q;
        wb_idx_d     = issue ? idx_q : wb_idx_q;
        wb_valid_d   = issue || (wb_valid_q && !bus.wb_ready);
        state_d      = accept ? ((vl_clamp == '0) ? DONE : RUN)
                     : (issue && last) ? DRAIN
                     : (state_q == DRAIN && retire) ? DONE
                     : (state_q == DONE) ? IDLE
                     : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            vl_q         <= '0;
            op_q         <= '0;
            vm_en_q      <= 1'b0;
            use_scalar_q <= 1'b0;
            scalar_q     <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            mask_q       <= '0;
            wb_valid_q   <= 1'b0;
            wb_idx_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vl_q         <= vl_d;
            op_q         <= op_d;
            vm_en_q      <= vm_en_d;
            use_scalar_q <= use_scalar_d;
            scalar_q     <= scalar_d;
            vs1_q        <= vs1_d;
            vs2_q        <= vs2_d;
            mask_q       <= mask_d;
            wb_valid_q   <= wb_valid_d;
            wb_idx_q     <= wb_idx_d;
            wb_data_q    <= wb_data_d;
        end
    end
endmodule

// File: tb/tb_valu_elem_seq.sv
// tb_valu_elem_seq: directed vectors with a writeback scoreboard and a small reference ALU.
module tb_valu_elem_seq;
    localparam int VLMAX = 8;
    localparam int IW    = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    valu_elem_seq_if #(.VLMAX(VLMAX)) bus ();
    valu_elem_seq #(.VLMAX(VLMAX)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } wb_t;
    wb_t exp_q[$];
    wb_t e;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  hs_cyc = 0;
    int  done_cnt = 0;
    bit  done_armed = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    // Reference ALU: add, sub, reverse-sub, merge; masked-off elements produce 0 except merge
    logic [31:0] a, b, r;
    always_comb begin
        a = bus.alu_opd1;
        b = bus.alu_opd2;
        r = 32'h0;
        case (bus.alu_op)
            5'b00000: r = a + b;
            5'b00001: r = a - b;
            5'b00010: r = b - a;
            5'b10101: r = bus.alu_vm ? b : a;
            default:  r = 32'h0;
        endcase
        bus.alu_result = (!bus.alu_vm && bus.alu_op != 5'b10101) ? 32'h0 : r;
    end
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    always @(negedge clk) begin
        if (bus.start && bus.start_ready) hs_cyc = cyc;
        if (bus.wb_valid && bus.wb_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got idx %0d data %0h expected no writeback", bus.wb_idx, bus.wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_idx", 32'(bus.wb_idx), 32'(e.idx));
                chk("wb_data", bus.wb_data, e.data);
            end
            hs_cyc = cyc;
        end
        if (bus.done) begin
            if (!done_armed) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 expected 0");
            end else begin
                chk("done_timing", 32'(cyc), 32'(hs_cyc + 1));
                chk("done_q_empty", 32'(exp_q.size()), 32'd0);
            end
            done_armed = 1'b0;
            done_cnt++;
        end
    end
    function automatic logic [255:0] pk(input logic [31:0] e0, e1 = 0, e2 = 0, e3 = 0,
                                        e4 = 0, e5 = 0, e6 = 0, e7 = 0);
        logic [31:0] t [8];
        logic [255:0] v;
        t = '{e0, e1, e2, e3, e4, e5, e6, e7};
        v = '0;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = t[i];
        return v;
    endfunction
    task automatic ex(input int n, input logic [255:0] d);
        wb_t w;
        for (int i = 0; i < n; i++) begin
            w.idx  = IW'(i);
            w.data = d[32*i +: 32];
            exp_q.push_back(w);
        end
    endtask
    task automatic go(input logic [4:0] op, input int vl, input bit vm, input bit us,
                      input logic [31:0] sc, input logic [255:0] v1, input logic [255:0] v2,
                      input logic [7:0] m);
        chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
        bus.op = op; bus.vl = IW'(vl); bus.vm_en = vm; bus.use_scalar = us;
        bus.scalar = sc; bus.vs1_data = v1; bus.vs2_data = v2; bus.v0_mask = m;
        done_armed = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 5'h1f; bus.scalar = '1; bus.vs1_data = '1; bus.vs2_data = '1; bus.v0_mask = '1;
    endtask
    task automatic wait_done();
        int c0 = done_cnt;
        int t = 0;
        while (done_cnt == c0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == c0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
    endtask
    task automatic wait_idx(input int k);
        int t = 0;
        while (!(bus.wb_valid && bus.wb_idx == IW'(k)) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wb_idx_reached", 32'(bus.wb_idx), 32'(k));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 0; bus.op = 0; bus.vl = 0; bus.vm_en = 0; bus.use_scalar = 0; bus.scalar = 0;
        bus.vs1_data = 0; bus.vs2_data = 0; bus.v0_mask = 0; bus.wb_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd0);
        chk("rst_alu_vm", 32'(bus.alu_vm), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        rst = 1'b0;
        #1;
        // 1: vadd, element 0 on ALU one cycle after accept, writeback the cycle after
        ex(4, pk(11, 22, 33, 44));
        go(5'b00000, 4, 0, 0, 0, pk(10, 20, 30, 40), pk(1, 2, 3, 4), 8'h00);
        chk("lat_busy", 32'(bus.busy), 32'd1);
        chk("lat_opd1", bus.alu_opd1, 32'd1);
        chk("lat_opd2", bus.alu_opd2, 32'd10);
        chk("lat_vm", 32'(bus.alu_vm), 32'd1);
        chk("lat_wb_valid0", 32'(bus.wb_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_wb_valid1", 32'(bus.wb_valid), 32'd1);
        chk("lat_wb_data", bus.wb_data, 32'd11);
        wait_done();
        // 2: scalar sub and reverse sub
        ex(3, pk(2, 0, 4));
        go(5'b00001, 3, 0, 1, 5, pk(100, 200, 300), pk(7, 5, 9), 8'h00);
        wait_done();
        ex(3, pk(32'hFFFFFFFE, 0, 32'hFFFFFFFC));
        go(5'b00010, 3, 0, 1, 5, pk(100, 200, 300), pk(7, 5, 9), 8'h00);
        wait_done();
        // 3: masked add and merge
        ex(4, pk(11, 0, 33, 0));
        go(5'b00000, 4, 1, 0, 0, pk(10, 20, 30, 40), pk(1, 2, 3, 4), 8'b0000_0101);
        wait_done();
        ex(4, pk(10, 2, 30, 4));
        go(5'b10101, 4, 1, 0, 0, pk(10, 20, 30, 40), pk(1, 2, 3, 4), 8'b0000_0101);
        wait_done();
        // 4: backpressure on element 1
        ex(4, pk(11, 22, 33, 44));
        go(5'b00000, 4, 0, 0, 0, pk(10, 20, 30, 40), pk(1, 2, 3, 4), 8'h00);
        wait_idx(1);
        bus.wb_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.wb_valid), 32'd1);
            chk("stall_idx", 32'(bus.wb_idx), 32'd1);
            chk("stall_data", bus.wb_data, 32'd22);
        end
        bus.wb_ready = 1'b1;
        wait_done();
        // 5: empty vector, then vl clamped to VLMAX
        go(5'b00000, 0, 0, 0, 0, pk(10), pk(1), 8'h00);
        wait_done();
        ex(8, pk(11, 22, 33, 44, 55, 66, 77, 88));
        go(5'b00000, 15, 0, 0, 0, pk(10, 20, 30, 40, 50, 60, 70, 80), pk(1, 2, 3, 4, 5, 6, 7, 8), 8'h00);
        wait_done();
        // 6: reset while element 2 is on the writeback port
        ex(3, pk(11, 22, 33));
        go(5'b00000, 8, 0, 0, 0, pk(10, 20, 30, 40, 50, 60, 70, 80), pk(1, 2, 3, 4, 5, 6, 7, 8), 8'h00);
        wait_idx(2);
        rst = 1'b1;
        done_armed = 1'b0;
        @(posedge clk); #1;
        chk("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        ex(4, pk(11, 22, 33, 44));
        go(5'b00000, 4, 0, 0, 0, pk(10, 20, 30, 40), pk(1, 2, 3, 4), 8'h00);
        wait_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
